// File: rtl/tdm_pkg.sv
// tdm_pkg: frame geometry and receiver state encoding shared by both ends of the TDM link
package tdm_pkg;

    localparam int TDM_N_CH = 4;
    localparam int TDM_W    = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_frame_buffer.sv
// tdm_frame_buffer: per-channel staging words and the atomically committed frame
module tdm_frame_buffer
    import tdm_pkg::*;
#(
    parameter  int N_CH = TDM_N_CH,
    parameter  int W    = TDM_W,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_idx,
    input  logic [W-1:0]      wr_data,
    input  logic              commit,
    output logic [N_CH*W-1:0] frame
);

    // The last channel is never staged: its word goes straight into the commit.
    for (genvar k = 0; k < N_CH - 1; k++) begin : g_ch
        logic [W-1:0] stage;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage <= '0;
            end else if (wr_en && wr_idx == CH_W'(k)) begin
                stage <= wr_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                frame[k*W +: W] <= '0;
            end else if (commit) begin
                frame[k*W +: W] <= stage;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame[(N_CH-1)*W +: W] <= '0;
        end else if (commit) begin
            frame[(N_CH-1)*W +: W] <= wr_data;
        end
    end

endmodule

// File: rtl/tdm_demultiplexor.sv
// tdm_demultiplexor: frame-locking FSM and channel counter that de-interleave a TDM word stream
module tdm_demultiplexor
    import tdm_pkg::*;
#(
    parameter  int N_CH = TDM_N_CH,
    parameter  int W    = TDM_W,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sync,
    input  logic [W-1:0]      in_data,
    output logic [N_CH*W-1:0] out_frame,
    output logic              frame_done,
    output logic [CH_W-1:0]   cur_ch,
    output logic              locked,
    output logic              sync_err
);

    tdm_state_t      state, state_nxt;
    logic [CH_W-1:0] cur_nxt;
    logic            mid, last, wr_en, commit, early, missing;

    assign locked = state == LOCKED;

    always_comb begin
        mid       = locked && cur_ch != '0;
        last      = cur_ch == CH_W'(N_CH - 1);
        wr_en     = in_valid && (in_sync || mid);
        commit    = in_valid && !in_sync && mid && last;
        early     = in_valid && in_sync && mid;
        missing   = in_valid && !in_sync && locked && cur_ch == '0;
        state_nxt = !in_valid ? state : in_sync ? LOCKED : missing ? HUNT : state;
        cur_nxt   = !in_valid ? cur_ch
                  : in_sync   ? CH_W'(1)
                  : commit    ? '0
                  : mid       ? cur_ch + CH_W'(1)
                  : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            cur_ch     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_ch     <= cur_nxt;
            frame_done <= commit;
            sync_err   <= early || missing;
        end
    end

    tdm_frame_buffer #(
        .N_CH (N_CH),
        .W    (W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (in_sync ? '0 : cur_ch),
        .wr_data (in_data),
        .commit  (commit),
        .frame   (out_frame)
    );

endmodule

// File: tb/tb_tdm_demultiplexor.sv
// tb_tdm_demultiplexor: directed-vector bench for the TDM demultiplexer
module tb_tdm_demultiplexor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sync = 1'b0;
    logic [7:0]  in_data = '0;
    logic [31:0] out_frame;
    logic        frame_done;
    logic [1:0]  cur_ch;
    logic        locked;
    logic        sync_err;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tdm_demultiplexor #(.N_CH(4), .W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_data    (in_data),
        .out_frame  (out_frame),
        .frame_done (frame_done),
        .cur_ch     (cur_ch),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Word is presented for exactly one rising edge; returns 1 time unit after it.
    task automatic send(input logic sync, input logic [7:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_sync  = sync;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 8'hxx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        check("rst_frame", out_frame, 32'h0);
        check("rst_done", frame_done, 0);
        check("rst_cur", cur_ch, 0);
        check("rst_locked", locked, 0);
        check("rst_err", sync_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(1, 8'h11); check("c1_cur1", cur_ch, 1); check("c1_lock", locked, 1);
        send(0, 8'h22); check("c1_cur2", cur_ch, 2);
        send(0, 8'h33); check("c1_cur3", cur_ch, 3); check("c1_nodone", frame_done, 0);
        send(0, 8'h44);
        check("c1_frame", out_frame, 32'h44332211);
        check("c1_done", frame_done, 1);
        check("c1_cur0", cur_ch, 0);
        idle(1);
        check("c1_done_pulse", frame_done, 0);

        send(1, 8'hA1); send(0, 8'hA2); send(0, 8'hA3); send(0, 8'hA4);
        check("c2_frame", out_frame, 32'hA4A3A2A1);
        check("c2_done", frame_done, 1);

        send(1, 8'h11); idle(5); check("gap_cur1", cur_ch, 1);
        send(0, 8'h22); idle(3); check("gap_cur2", cur_ch, 2); check("gap_nodone", frame_done, 0);
        send(0, 8'h33); check("gap_cur3", cur_ch, 3);
        idle(2); check("gap_hold", out_frame, 32'hA4A3A2A1);
        send(0, 8'h44);
        check("gap_frame", out_frame, 32'h44332211);
        check("gap_done", frame_done, 1);
        check("gap_cur0", cur_ch, 0);

        reset_pulse();
        send(0, 8'h55); check("hunt_lock1", locked, 0); check("hunt_err1", sync_err, 0);
        send(0, 8'h66); check("hunt_lock2", locked, 0); check("hunt_err2", sync_err, 0);
        check("hunt_cur", cur_ch, 0);
        send(1, 8'h01); check("hunt_locked", locked, 1);
        send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
        check("hunt_frame", out_frame, 32'h04030201);
        check("hunt_done", frame_done, 1);

        send(0, 8'h99);
        check("miss_err", sync_err, 1);
        check("miss_lock", locked, 0);
        check("miss_frame", out_frame, 32'h04030201);
        check("miss_cur", cur_ch, 0);
        idle(1);
        check("miss_err_pulse", sync_err, 0);

        send(1, 8'h10); send(0, 8'h20);
        send(1, 8'h30);
        check("early_err", sync_err, 1);
        check("early_cur", cur_ch, 1);
        check("early_lock", locked, 1);
        check("early_nodone", frame_done, 0);
        check("early_frame", out_frame, 32'h04030201);
        send(0, 8'h40); check("early_err_pulse", sync_err, 0);
        send(0, 8'h50); check("early_nodone2", frame_done, 0);
        send(0, 8'h60);
        check("early_commit", out_frame, 32'h60504030);
        check("early_done", frame_done, 1);

        send(1, 8'h77); send(0, 8'h88);
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_frame", out_frame, 32'h0);
        check("amid_cur", cur_ch, 0);
        check("amid_lock", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 8'hC1); send(0, 8'hC2); send(0, 8'hC3); send(0, 8'hC4);
        check("post_rst_frame", out_frame, 32'hC4C3C2C1);
        check("post_rst_done", frame_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
